// File: rtl/tcdm_bank_shim.sv
// tcdm_bank_shim: bridges the tile-side TCDM slave request/response channel to
// one single-port SRAM bank with 1-cycle read latency. Responses return in
// acceptance order through a fall-through FIFO of depth NumOutstanding.
// Optional atomics are compiled in with the macro TCDM_SHIM_AMO_EN.
// The payload layout mirrors mempool_pkg::tcdm_payload_t as
// {meta_id, core_id, amo[3:0], data[31:0]}.
//
// state  | meaning
// IDLE   | normal operation, requests accepted while FIFO space remains
// AMO_WB | AMO write-back cycle, request side stalled
module tcdm_bank_shim #(
    parameter int unsigned NumOutstanding = 2,
    parameter int unsigned BankAddrWidth  = 10,
    parameter int unsigned MetaIdWidth    = 4,
    parameter int unsigned CoreIdWidth    = 8,
    parameter int unsigned IniAddrWidth   = 4,
    localparam int unsigned BeWidth       = 4,
    localparam int unsigned DataWidth     = 32,
    localparam int unsigned AmoWidth      = 4,
    localparam int unsigned PayloadWidth  = MetaIdWidth + CoreIdWidth + AmoWidth + DataWidth
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [BankAddrWidth-1:0] req_addr_i,
    input  logic                     req_wen_i,
    input  logic [BeWidth-1:0]       req_be_i,
    input  logic [PayloadWidth-1:0]  req_payload_i,
    input  logic [IniAddrWidth-1:0]  req_ini_addr_i,
    output logic                     resp_valid_o,
    input  logic                     resp_ready_i,
    output logic [PayloadWidth-1:0]  resp_payload_o,
    output logic [IniAddrWidth-1:0]  resp_ini_addr_o,
    output logic                     mem_req_o,
    output logic                     mem_we_o,
    output logic [BankAddrWidth-1:0] mem_addr_o,
    output logic [BeWidth-1:0]       mem_be_o,
    output logic [DataWidth-1:0]     mem_wdata_o,
    input  logic [DataWidth-1:0]     mem_rdata_i
);

    localparam int unsigned TagWidth   = PayloadWidth - DataWidth;
    localparam int unsigned EntryWidth = IniAddrWidth + PayloadWidth;
    localparam int unsigned PtrWidth   = (NumOutstanding > 1) ? $clog2(NumOutstanding) : 1;
    localparam int unsigned CntWidth   = $clog2(NumOutstanding + 1);
    localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(NumOutstanding - 1);

    typedef enum logic {IDLE, AMO_WB} state_e;

    state_e                   state_q, state_d;
    logic                     accept, is_amo_req;
    logic [DataWidth-1:0]     req_data, amo_result;
    logic [BankAddrWidth-1:0] amo_addr;

    logic                     inflight_q, pend_write_q;
    logic [TagWidth-1:0]      pend_tag_q;
    logic [IniAddrWidth-1:0]  pend_ini_q;
    logic [DataWidth-1:0]     pend_rdata;
    logic [EntryWidth-1:0]    pend_entry, resp_entry;

    logic [EntryWidth-1:0]    fifo_mem [NumOutstanding];
    logic [PtrWidth-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CntWidth-1:0]      fifo_count_q;
    logic                     fifo_empty, resp_pop, bypass, push, pop_fifo;

    assign req_data = req_payload_i[DataWidth-1:0];

    // A pop in this cycle does not free space for an acceptance in this cycle.
    assign req_ready_o = !rst_i && (state_q == IDLE) &&
                         ((32'(fifo_count_q) + 32'(inflight_q)) < NumOutstanding);
    assign accept      = req_valid_i && req_ready_o;

`ifdef TCDM_SHIM_AMO_EN
    logic [AmoWidth-1:0]      req_amo, amo_op_q;
    logic [DataWidth-1:0]     amo_opnd_q;
    logic [BankAddrWidth-1:0] amo_addr_q;

    assign req_amo    = req_payload_i[DataWidth +: AmoWidth];
    assign is_amo_req = (req_amo >= 4'd1) && (req_amo <= 4'd9);
    assign amo_addr   = amo_addr_q;

    // Hold the AMO opcode, operand and address for the write-back cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            amo_op_q   <= '0;
            amo_opnd_q <= '0;
            amo_addr_q <= '0;
        end else if (accept) begin
            amo_op_q   <= req_amo;
            amo_opnd_q <= req_data;
            amo_addr_q <= req_addr_i;
        end
    end

    // Combine the old word (arriving from the bank) with the AMO operand.
    always_comb begin
        amo_result = mem_rdata_i;
        case (amo_op_q)
            4'd1: amo_result = amo_opnd_q;
            4'd2: amo_result = mem_rdata_i + amo_opnd_q;
            4'd3: amo_result = mem_rdata_i & amo_opnd_q;
            4'd4: amo_result = mem_rdata_i | amo_opnd_q;
            4'd5: amo_result = mem_rdata_i ^ amo_opnd_q;
            4'd6: amo_result = ($signed(mem_rdata_i) > $signed(amo_opnd_q)) ? mem_rdata_i : amo_opnd_q;
            4'd7: amo_result = (mem_rdata_i > amo_opnd_q) ? mem_rdata_i : amo_opnd_q;
            4'd8: amo_result = ($signed(mem_rdata_i) < $signed(amo_opnd_q)) ? mem_rdata_i : amo_opnd_q;
            4'd9: amo_result = (mem_rdata_i < amo_opnd_q) ? mem_rdata_i : amo_opnd_q;
            default: amo_result = mem_rdata_i;
        endcase
    end
`else
    assign is_amo_req = 1'b0;
    assign amo_result = '0;
    assign amo_addr   = '0;
`endif

    // Track the access issued last cycle; its response is formed next cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            inflight_q   <= 1'b0;
            pend_write_q <= 1'b0;
            pend_tag_q   <= '0;
            pend_ini_q   <= '0;
        end else begin
            inflight_q <= accept;
            if (accept) begin
                pend_write_q <= req_wen_i && !is_amo_req;
                pend_tag_q   <= req_payload_i[PayloadWidth-1:DataWidth];
                pend_ini_q   <= req_ini_addr_i;
            end
        end
    end

    assign pend_rdata = pend_write_q ? '0 : mem_rdata_i;
    assign pend_entry = {pend_ini_q, pend_tag_q, pend_rdata};

    assign fifo_empty = (fifo_count_q == '0);
    assign resp_entry = !fifo_empty ? fifo_mem[rd_ptr_q] : (inflight_q ? pend_entry : '0);
    assign resp_valid_o    = inflight_q || !fifo_empty;
    assign resp_payload_o  = resp_entry[PayloadWidth-1:0];
    assign resp_ini_addr_o = resp_entry[EntryWidth-1:PayloadWidth];

    // An empty FIFO lets the fresh response fall straight through when taken.
    assign resp_pop = resp_valid_o && resp_ready_i;
    assign bypass   = inflight_q && fifo_empty && resp_pop;
    assign push     = inflight_q && !bypass;
    assign pop_fifo = resp_pop && !fifo_empty;

    // FIFO pointers and occupancy; pointers wrap at NumOutstanding.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
        end else begin
            if (push) wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
            if (pop_fifo) rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
            if (push && !pop_fifo) fifo_count_q <= fifo_count_q + 1'b1;
            else if (pop_fifo && !push) fifo_count_q <= fifo_count_q - 1'b1;
        end
    end

    // FIFO storage needs no reset; occupancy alone qualifies its contents.
    always_ff @(posedge clk_i) begin
        if (push) fifo_mem[wr_ptr_q] <= pend_entry;
    end

    // FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM next state: an accepted AMO spends exactly one cycle in write-back.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (accept && is_amo_req) state_d = AMO_WB;
            AMO_WB: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: bank port driven by write-back or by the accepted request.
    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_be_o    = '0;
        mem_wdata_o = '0;
        if (state_q == AMO_WB) begin
            mem_req_o   = 1'b1;
            mem_we_o    = 1'b1;
            mem_addr_o  = amo_addr;
            mem_be_o    = 4'hF;
            mem_wdata_o = amo_result;
        end else if (accept) begin
            mem_req_o   = 1'b1;
            mem_we_o    = req_wen_i && !is_amo_req;
            mem_addr_o  = req_addr_i;
            mem_be_o    = req_be_i;
            mem_wdata_o = req_data;
        end
    end

endmodule

// File: tb/tb_tcdm_bank_shim.sv
// Bench for tcdm_bank_shim: table of per-cycle vectors plus hand-written
// sequences for reset, AMO write-back and AMO-disabled behaviour.
module tb_tcdm_bank_shim;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [9:0]  req_addr_i = '0;
    logic        req_wen_i = 1'b0;
    logic [3:0]  req_be_i = '0;
    logic [47:0] req_payload_i = '0;
    logic [3:0]  req_ini_addr_i = '0;
    logic        resp_valid_o;
    logic        resp_ready_i = 1'b1;
    logic [47:0] resp_payload_o;
    logic [3:0]  resp_ini_addr_o;
    logic        mem_req_o, mem_we_o;
    logic [9:0]  mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i = '0;

    logic [31:0] tb_mem [1024];
    logic        bd_en = 1'b0;
    logic [9:0]  bd_addr = '0;
    logic [31:0] bd_data = '0;

    int n_applied = 0;
    int n_miss = 0;

    tcdm_bank_shim dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i), .req_wen_i(req_wen_i), .req_be_i(req_be_i),
        .req_payload_i(req_payload_i), .req_ini_addr_i(req_ini_addr_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .resp_payload_o(resp_payload_o), .resp_ini_addr_o(resp_ini_addr_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // SRAM bank model with 1-cycle read latency and a backdoor preload port.
    always @(posedge clk_i) begin
        if (bd_en) begin
            tb_mem[bd_addr] <= bd_data;
        end else if (mem_req_o) begin
            if (mem_we_o)
                for (int b = 0; b < 4; b++)
                    if (mem_be_o[b]) tb_mem[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
            mem_rdata_i <= tb_mem[mem_addr_o];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic preload(input logic [9:0] a, input logic [31:0] d);
        @(negedge clk_i);
        bd_en = 1'b1; bd_addr = a; bd_data = d;
    endtask

    typedef struct packed {
        logic        valid;
        logic        wen;
        logic [9:0]  addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [3:0]  meta;
        logic        rr;
        logic        exp_ready;
        logic        exp_rvalid;
        logic [31:0] exp_rdata;
        logic [3:0]  exp_meta;
    } vec_t;

    vec_t vecs [15];

`ifdef TCDM_SHIM_AMO_EN
    task automatic amo_op(input logic [9:0] a, input logic [3:0] op, input logic [31:0] opnd,
                          input logic [31:0] old_v, input logic [31:0] new_v);
        @(negedge clk_i);
        req_valid_i = 1'b1; req_addr_i = a; req_wen_i = 1'b0; req_be_i = 4'hF;
        req_payload_i = {4'h9, 8'h99, op, opnd}; req_ini_addr_i = 4'h9; resp_ready_i = 1'b1;
        #1;
        check("amo_rd_ready", req_ready_o, 1'b1);
        check("amo_rd_we", mem_we_o, 1'b0);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        #1;
        check("amo_wb_ready", req_ready_o, 1'b0);
        check("amo_wb_req", {mem_req_o, mem_we_o, mem_be_o}, {1'b1, 1'b1, 4'hF});
        check("amo_wb_addr", mem_addr_o, a);
        check("amo_wb_data", mem_wdata_o, new_v);
        check("amo_resp_valid", resp_valid_o, 1'b1);
        check("amo_resp_old", resp_payload_o[31:0], old_v);
        @(negedge clk_i);
        #1;
        check("amo_mem", tb_mem[a], new_v);
        check("amo_after_ready", req_ready_o, 1'b1);
        check("amo_after_rvalid", resp_valid_o, 1'b0);
    endtask
`endif

    initial begin
        // valid wen addr be wdata meta rr | ready rvalid rdata meta
        vecs[0]  = '{1'b1, 1'b0, 10'd5, 4'hF, 32'h0,        4'd3, 1'b1, 1'b1, 1'b0, 32'h0,        4'd0};
        vecs[1]  = '{1'b0, 1'b0, 10'd0, 4'h0, 32'h0,        4'd0, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 4'd3};
        vecs[2]  = '{1'b1, 1'b1, 10'd6, 4'h3, 32'h12345678, 4'd4, 1'b1, 1'b1, 1'b0, 32'h0,        4'd0};
        vecs[3]  = '{1'b1, 1'b0, 10'd6, 4'hF, 32'h0,        4'd5, 1'b1, 1'b1, 1'b1, 32'h0,        4'd4};
        vecs[4]  = '{1'b0, 1'b0, 10'd0, 4'h0, 32'h0,        4'd0, 1'b1, 1'b1, 1'b1, 32'hFFFF5678, 4'd5};
        vecs[5]  = '{1'b0, 1'b0, 10'd0, 4'h0, 32'h0,        4'd0, 1'b1, 1'b1, 1'b0, 32'h0,        4'd0};
        vecs[6]  = '{1'b1, 1'b0, 10'd7, 4'hF, 32'h0,        4'd6, 1'b0, 1'b1, 1'b0, 32'h0,        4'd0};
        vecs[7]  = '{1'b1, 1'b0, 10'd8, 4'hF, 32'h0,        4'd7, 1'b0, 1'b1, 1'b1, 32'h11111111, 4'd6};
        vecs[8]  = '{1'b1, 1'b0, 10'd9, 4'hF, 32'h0,        4'd8, 1'b0, 1'b0, 1'b1, 32'h11111111, 4'd6};
        vecs[9]  = '{1'b1, 1'b0, 10'd9, 4'hF, 32'h0,        4'd8, 1'b0, 1'b0, 1'b1, 32'h11111111, 4'd6};
        vecs[10] = '{1'b1, 1'b0, 10'd9, 4'hF, 32'h0,        4'd8, 1'b1, 1'b0, 1'b1, 32'h11111111, 4'd6};
        vecs[11] = '{1'b1, 1'b0, 10'd9, 4'hF, 32'h0,        4'd8, 1'b0, 1'b1, 1'b1, 32'h22222222, 4'd7};
        vecs[12] = '{1'b0, 1'b0, 10'd0, 4'h0, 32'h0,        4'd0, 1'b1, 1'b0, 1'b1, 32'h22222222, 4'd7};
        vecs[13] = '{1'b0, 1'b0, 10'd0, 4'h0, 32'h0,        4'd0, 1'b1, 1'b1, 1'b1, 32'h33333333, 4'd8};
        vecs[14] = '{1'b0, 1'b0, 10'd0, 4'h0, 32'h0,        4'd0, 1'b1, 1'b1, 1'b0, 32'h0,        4'd0};

        // Preload while held in reset; a request is presented to prove it is ignored.
        req_valid_i = 1'b1; req_addr_i = 10'd5; req_be_i = 4'hF;
        preload(10'd5, 32'hDEADBEEF);
        preload(10'd6, 32'hFFFFFFFF);
        preload(10'd7, 32'h11111111);
        preload(10'd8, 32'h22222222);
        preload(10'd9, 32'h33333333);
        preload(10'd10, 32'hFFFFFFFF);
        preload(10'd11, 32'hFFFFFFFF);
        preload(10'd12, 32'h80000000);
        preload(10'd13, 32'h000000AA);
        @(negedge clk_i);
        bd_en = 1'b0;
        #1;
        check("rst_req_ready", req_ready_o, 1'b0);
        check("rst_mem_req", mem_req_o, 1'b0);
        check("rst_resp_valid", resp_valid_o, 1'b0);
        check("rst_mem_addr", mem_addr_o, 10'd0);
        check("rst_resp_payload", resp_payload_o, 48'h0);

        for (int i = 0; i < 15; i++) begin
            @(negedge clk_i);
            if (i == 0) rst_i = 1'b0;
            req_valid_i    = vecs[i].valid;
            req_wen_i      = vecs[i].wen;
            req_addr_i     = vecs[i].addr;
            req_be_i       = vecs[i].be;
            req_payload_i  = {vecs[i].meta, vecs[i].meta, vecs[i].meta, 4'h0, vecs[i].wdata};
            req_ini_addr_i = vecs[i].meta;
            resp_ready_i   = vecs[i].rr;
            #1;
            check($sformatf("v%0d_req_ready", i), req_ready_o, vecs[i].exp_ready);
            check($sformatf("v%0d_mem_req", i), mem_req_o, vecs[i].valid & vecs[i].exp_ready);
            check($sformatf("v%0d_resp_valid", i), resp_valid_o, vecs[i].exp_rvalid);
            if (vecs[i].exp_rvalid) begin
                check($sformatf("v%0d_resp_payload", i), resp_payload_o,
                      {vecs[i].exp_meta, vecs[i].exp_meta, vecs[i].exp_meta, 4'h0, vecs[i].exp_rdata});
                check($sformatf("v%0d_resp_ini", i), resp_ini_addr_o, vecs[i].exp_meta);
            end
        end
        check("mem6_after_partial_write", tb_mem[6], 32'hFFFF5678);

`ifdef TCDM_SHIM_AMO_EN
        @(negedge clk_i);
        req_valid_i = 1'b0;
        amo_op(10'd10, 4'd2, 32'h00000001, 32'hFFFFFFFF, 32'h00000000);
        amo_op(10'd11, 4'd6, 32'h00000005, 32'hFFFFFFFF, 32'h00000005);
        amo_op(10'd11, 4'd7, 32'hFFFFFFF0, 32'h00000005, 32'hFFFFFFF0);
        amo_op(10'd12, 4'd8, 32'h00000001, 32'h80000000, 32'h80000000);
        amo_op(10'd10, 4'd5, 32'h0F0F0F0F, 32'h00000000, 32'h0F0F0F0F);

        // Reset landing in the write-back cycle must abort the SWAP entirely.
        @(negedge clk_i);
        req_valid_i = 1'b1; req_addr_i = 10'd13; req_wen_i = 1'b0; req_be_i = 4'hF;
        req_payload_i = {4'h1, 8'h11, 4'd1, 32'h00000055}; resp_ready_i = 1'b0;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        #1;
        check("abort_in_wb", {mem_req_o, mem_we_o}, 2'b11);
        rst_i = 1'b1;
        #1;
        check("abort_mem_req", mem_req_o, 1'b0);
        check("abort_resp_valid", resp_valid_o, 1'b0);
        @(negedge clk_i);
        #1;
        check("abort_mem_unchanged", tb_mem[13], 32'h000000AA);
        rst_i = 1'b0;
        @(negedge clk_i);
        #1;
        check("abort_fifo_empty", resp_valid_o, 1'b0);
        check("abort_ready", req_ready_o, 1'b1);
`else
        // AMO code is only echoed: a plain read, no write-back, ready stays high.
        @(negedge clk_i);
        req_valid_i = 1'b1; req_addr_i = 10'd6; req_wen_i = 1'b0; req_be_i = 4'hF;
        req_payload_i = {4'h2, 8'h22, 4'd1, 32'hAAAAAAAA}; req_ini_addr_i = 4'h2; resp_ready_i = 1'b1;
        #1;
        check("noamo_rd_we", mem_we_o, 1'b0);
        check("noamo_rd_ready", req_ready_o, 1'b1);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        #1;
        check("noamo_ready_high", req_ready_o, 1'b1);
        check("noamo_no_wb", mem_req_o, 1'b0);
        check("noamo_resp_valid", resp_valid_o, 1'b1);
        check("noamo_resp_payload", resp_payload_o, {4'h2, 8'h22, 4'd1, 32'hFFFF5678});
        @(negedge clk_i);
        #1;
        check("noamo_mem_unchanged", tb_mem[6], 32'hFFFF5678);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
        $finish;
    end

endmodule
